// File: rtl/uart_autobaud.sv
// uart_autobaud: measures the host bit period from a 0x55 sync byte on rx_in
// and publishes it as cycles_per_bit for the downstream uart_rx/uart_tx.
// Optional feature macro: UART_AUTOBAUD_RELOCK_EN (a long break on the line
// while locked drops the lock and restarts detection).
module uart_autobaud #(
  parameter int COUNTER_WIDTH          = 24,
  parameter int DEFAULT_CYCLES_PER_BIT = 104,
  parameter int MIN_CYCLES_PER_BIT     = 8,
  parameter int IDLE_CYCLES            = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_in,
  input  logic                     rearm,
  output logic [COUNTER_WIDTH-1:0] cycles_per_bit,
  output logic                     locked,
  output logic                     err
);

  localparam int CW     = COUNTER_WIDTH;
  localparam int TW     = COUNTER_WIDTH + 3;
  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);

  typedef enum logic [2:0] {
    ARM,
    HUNT,
    MEAS,
    STOP,
    LOCKED,
    FAIL
  } state_t;

  state_t state;
  state_t state_next;

  logic              rx_sync1;
  logic              rx_s;
  logic              rx_prev;
  logic              rise;
  logic              fall;
  logic              any_edge;

  logic [IDLE_W-1:0] idle_cnt;
  logic [CW-1:0]     seg;
  logic [CW-1:0]     t0;
  logic [TW-1:0]     total;
  logic [TW-1:0]     total_rnd;
  logic [TW-1:0]     total_shr;
  logic [TW-1:0]     result_q;
  logic [3:0]        edge_idx;

  logic [CW-1:0]     seg_diff;
  logic              seg_ok;
  logic              seg_sat;
  logic              seg_over;
  logic              timeout;
  logic              result_ok;

`ifdef UART_AUTOBAUD_RELOCK_EN
  logic [CW+3:0]     brk_cnt;
  logic              brk_hit;
`endif

  // Bring the asynchronous line into the clock domain and keep one delayed copy for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync1 <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
    end else begin
      rx_sync1 <= rx_in;
      rx_s     <= rx_sync1;
      rx_prev  <= rx_s;
    end
  end

  assign rise     = rx_s & ~rx_prev;
  assign fall     = ~rx_s & rx_prev;
  assign any_edge = rise | fall;

  // Segment checks: tolerance against the start bit, saturation and the 2*T0 timeout
  assign seg_diff  = (seg >= t0) ? (seg - t0) : (t0 - seg);
  assign seg_ok    = (seg_diff <= (t0 >> 2));
  assign seg_sat   = &seg;
  assign seg_over  = ({1'b0, seg} > {t0, 1'b0});
  assign timeout   = seg_sat || ((edge_idx != 4'd0) && seg_over);
  assign total_rnd = total + TW'(4);
  assign total_shr = total_rnd >> 3;
  assign result_ok = (result_q[TW-1:CW] == 3'b000) &&
                     (result_q >= TW'(MIN_CYCLES_PER_BIT));

  // Count consecutive high samples while armed so a start bit is only hunted on an idle line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt <= '0;
    end else if ((state == ARM) && rx_s) begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end else begin
      idle_cnt <= '0;
    end
  end

`ifdef UART_AUTOBAUD_RELOCK_EN
  // While locked, measure how long the line has been held low to spot a host break
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      brk_cnt <= '0;
    end else if ((state == LOCKED) && !rx_s) begin
      brk_cnt <= brk_cnt + (CW + 4)'(1);
    end else begin
      brk_cnt <= '0;
    end
  end

  assign brk_hit = !rx_s && ((brk_cnt + (CW + 4)'(1)) >= {cycles_per_bit, 4'b0000});
`endif

  // Measurement datapath: per-segment length, running total, start-bit reference and result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg      <= '0;
      total    <= '0;
      t0       <= '0;
      edge_idx <= '0;
      result_q <= '0;
    end else begin
      case (state)
        HUNT: begin
          if (fall) begin
            seg      <= '0;
            total    <= '0;
            edge_idx <= '0;
          end
        end
        MEAS: begin
          total <= total + TW'(1);
          if (any_edge) begin
            edge_idx <= edge_idx + 4'd1;
            seg      <= CW'(1);
            if (edge_idx == 4'd0) begin
              t0 <= seg;
            end
            if (edge_idx == 4'd7) begin
              result_q <= total_shr;
            end
          end else if (!seg_sat) begin
            seg <= seg + CW'(1);
          end
        end
        STOP: begin
          if (!seg_sat) begin
            seg <= seg + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARM;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode; rearm overrides every other transition
  always_comb begin
    state_next = state;
    locked     = (state == LOCKED);
    err        = (state == FAIL);
    case (state)
      ARM: begin
        if (rx_s && (idle_cnt == IDLE_W'(IDLE_CYCLES - 1))) begin
          state_next = HUNT;
        end
      end
      HUNT: begin
        if (fall) begin
          state_next = MEAS;
        end
      end
      MEAS: begin
        if (any_edge) begin
          if ((edge_idx != 4'd0) && !seg_ok) begin
            state_next = FAIL;
          end else if (edge_idx == 4'd7) begin
            state_next = STOP;
          end
        end else if (timeout) begin
          state_next = FAIL;
        end
      end
      STOP: begin
        if (rise) begin
          if (seg_ok && result_ok) begin
            state_next = LOCKED;
          end else begin
            state_next = FAIL;
          end
        end else if (timeout) begin
          state_next = FAIL;
        end
      end
      LOCKED: begin
`ifdef UART_AUTOBAUD_RELOCK_EN
        if (brk_hit) begin
          state_next = ARM;
        end
`endif
      end
      FAIL: begin
        state_next = ARM;
      end
      default: begin
        state_next = ARM;
      end
    endcase
    if (rearm) begin
      state_next = ARM;
    end
  end

  // Publish the measured rate only when a sync attempt actually completes into LOCKED
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycles_per_bit <= CW'(DEFAULT_CYCLES_PER_BIT);
    end else if ((state == STOP) && (state_next == LOCKED)) begin
      cycles_per_bit <= result_q[CW-1:0];
    end
  end

endmodule

// File: tb/tb_uart_autobaud.sv
// tb_uart_autobaud: scoreboard bench for uart_autobaud. Expected lock/err
// events are queued as frames are sent and matched as the DUT produces them.
// Honours UART_AUTOBAUD_RELOCK_EN for the break scenario.
module tb_uart_autobaud;

  localparam int CW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx_in = 1'b1;
  logic          rearm = 1'b0;
  logic [CW-1:0] cycles_per_bit;
  logic          locked;
  logic          err;

  int num_checks = 0;
  int num_errors = 0;

  typedef struct {
    bit            is_lock;
    logic [CW-1:0] cpb;
  } sb_evt_t;

  sb_evt_t sb_q[$];
  bit      locked_prev = 1'b0;
  bit      err_prev    = 1'b0;

  uart_autobaud dut (
    .clk            (clk),
    .rst            (rst),
    .rx_in          (rx_in),
    .rearm          (rearm),
    .cycles_per_bit (cycles_per_bit),
    .locked         (locked),
    .err            (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expectLock(input logic [CW-1:0] cpb);
    sb_evt_t e;
    e.is_lock = 1'b1;
    e.cpb     = cpb;
    sb_q.push_back(e);
  endtask

  task automatic expectErr();
    sb_evt_t e;
    e.is_lock = 1'b0;
    e.cpb     = '0;
    sb_q.push_back(e);
  endtask

  // Idle line, then start bit and data bits LSB first. Even segments (start, b1,
  // b3, ...) last len_even cycles, odd ones len_odd. After n_seg segments the
  // line is left at the level of the next segment (stop bit when n_seg = 9).
  task automatic applyStimulus(input logic [7:0] data, input int len_even,
                               input int len_odd, input int n_seg);
    logic [9:0] frame;
    frame = {1'b1, data, 1'b0};
    rx_in = 1'b1;
    wait_cycles(40);
    for (int i = 0; i < n_seg; i++) begin
      rx_in = frame[i];
      wait_cycles((i % 2 == 0) ? len_even : len_odd);
    end
    rx_in = frame[n_seg];
  endtask

  task automatic drainScoreboard(input string tag, input int budget);
    int n;
    n = 0;
    while ((sb_q.size() != 0) && (n < budget)) begin
      wait_cycles(1);
      n++;
    end
    checkOutput(tag, sb_q.size(), 0);
  endtask

  task automatic pulseRearm();
    rearm = 1'b1;
    wait_cycles(1);
    rearm = 1'b0;
  endtask

  task automatic matchEvent(input bit is_lock);
    sb_evt_t e;
    if (sb_q.size() == 0) begin
      checkOutput(is_lock ? "unexpected_lock" : "unexpected_err", 1, 0);
    end else begin
      e = sb_q.pop_front();
      checkOutput("event_kind_is_lock", {31'b0, is_lock}, {31'b0, e.is_lock});
      if (is_lock) begin
        checkOutput("lock_cpb", cycles_per_bit, e.cpb);
      end
    end
  endtask

  // Monitor: sample on the falling edge and match lock/err events to the queue
  always @(negedge clk) begin
    if (!rst) begin
      locked_prev = 1'b0;
      err_prev    = 1'b0;
    end else begin
      if (err_prev) begin
        checkOutput("err_pulse_width", {31'b0, err}, 0);
      end
      if (locked && !locked_prev) begin
        matchEvent(1'b1);
      end
      if (err && !err_prev) begin
        matchEvent(1'b0);
      end
      locked_prev = locked;
      err_prev    = err;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;

    rst   = 1'b0;
    rx_in = 1'b1;
    wait_cycles(3);
    checkOutput("reset_cpb", cycles_per_bit, 104);
    checkOutput("reset_locked", {31'b0, locked}, 0);
    checkOutput("reset_err", {31'b0, err}, 0);
    rst = 1'b1;
    wait_cycles(2);

    // 0x41: rejected while its long low run times out; the b6 high run then
    // re-arms, b7 starts a fresh attempt that times out after the stop rise.
    expectErr();
    expectErr();
    applyStimulus(8'h41, 104, 104, 9);
    wait_cycles(400);
    drainScoreboard("sb_0x41", 10);
    checkOutput("bad_frame_locked", {31'b0, locked}, 0);
    checkOutput("bad_frame_cpb", cycles_per_bit, 104);

    expectLock(52);
    applyStimulus(8'h55, 52, 52, 9);
    drainScoreboard("sb_52", 20);

    pulseRearm();
    checkOutput("rearm_locked", {31'b0, locked}, 0);
    checkOutput("rearm_cpb_hold", cycles_per_bit, 52);

    // 4 cycles/bit: start-bit reference of 3 leaves zero tolerance -> reject
    expectErr();
    applyStimulus(8'h55, 4, 4, 9);
    wait_cycles(40);
    drainScoreboard("sb_4", 10);
    checkOutput("fast_locked", {31'b0, locked}, 0);
    checkOutput("fast_cpb_hold", cycles_per_bit, 52);

    expectLock(104);
    applyStimulus(8'h55, 104, 104, 9);
    lat = 0;
    while (!locked && (lat < 10)) begin
      wait_cycles(1);
      lat++;
    end
    checkOutput("lock_latency_le4", {31'b0, (locked && (lat <= 4))}, 1);
    drainScoreboard("sb_104", 10);

    // Break of 16 * 104 cycles while locked
    rx_in = 1'b0;
    wait_cycles(1664);
    rx_in = 1'b1;
    wait_cycles(5);
`ifdef UART_AUTOBAUD_RELOCK_EN
    checkOutput("break_locked", {31'b0, locked}, 0);
    checkOutput("break_cpb_hold", cycles_per_bit, 104);
    expectLock(104);
    applyStimulus(8'h55, 104, 104, 9);
    drainScoreboard("sb_relock", 10);
`else
    checkOutput("break_locked", {31'b0, locked}, 1);
    checkOutput("break_cpb_hold", cycles_per_bit, 104);
`endif

    // Alternating 1090/910 segments average to 1000
    pulseRearm();
    expectLock(1000);
    applyStimulus(8'h55, 1090, 910, 9);
    drainScoreboard("sb_1000", 10);

    // Reset shortly after edge 5 of a 200 cycles/bit sync byte
    pulseRearm();
    applyStimulus(8'h55, 200, 200, 5);
    wait_cycles(3);
    rst = 1'b0;
    #1;
    checkOutput("midsync_reset_cpb", cycles_per_bit, 104);
    checkOutput("midsync_reset_locked", {31'b0, locked}, 0);
    checkOutput("midsync_reset_err", {31'b0, err}, 0);
    wait_cycles(2);
    rst = 1'b1;
    wait_cycles(2);

    expectLock(200);
    applyStimulus(8'h55, 200, 200, 9);
    drainScoreboard("sb_200", 10);

    wait_cycles(10);
    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
